// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with priority-encoded redirects, a circular return-address
// stack, an exception/eret path and a RUN/HALTED control state.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(32'h0000_0080),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            link,
  input  logic            ret,
  input  logic [XLEN-1:0] ret_target,
  input  logic            exception,
  input  logic            eret,
  input  logic            halt,
  input  logic            resume,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc,
  output logic            misalign,
  output logic            halted,
  output logic            ras_empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  typedef enum logic {RUN, HALTED} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc_next, epc_next;
  logic            misalign_next;
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr;
  logic [CW-1:0]   ras_cnt;
  logic            ras_push, ras_pop;
  logic [XLEN-1:0] ras_top, ret_addr;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;

  assign pc_plus4  = pc_out + XLEN'(4);
  assign halted    = (state == HALTED);
  assign ras_empty = (ras_cnt == '0);
  assign ras_top   = ras_mem[ras_ptr - PW'(1)];
  assign ret_addr  = ras_empty ? ret_target : ras_top;

  always_comb begin
    state_next      = state;
    pc_next         = pc_out;
    epc_next        = epc;
    misalign_next   = 1'b0;
    ras_push        = 1'b0;
    ras_pop         = 1'b0;
    redirect        = 1'b0;
    redirect_target = '0;
    case (state)
      RUN: begin
        if (exception) begin
          pc_next  = EXC_VECTOR;
          epc_next = pc_out;
        end else if (eret) begin
          pc_next = epc;
        end else if (branch_taken) begin
          redirect        = 1'b1;
          redirect_target = branch_target;
        end else if (jump) begin
          redirect        = 1'b1;
          redirect_target = jump_target;
          ras_push        = link;
        end else if (ret) begin
          redirect        = 1'b1;
          redirect_target = ret_addr;
          ras_pop         = !ras_empty;
        end else if (halt) begin
          pc_next    = pc_plus4;
          state_next = HALTED;
        end else if (!stall) begin
          pc_next = pc_plus4;
        end
        // A misaligned redirect traps instead, recording the bad target in epc.
        if (redirect) begin
          if (redirect_target[1:0] != 2'b00) begin
            pc_next       = EXC_VECTOR;
            epc_next      = redirect_target;
            misalign_next = 1'b1;
          end else begin
            pc_next = redirect_target;
          end
        end
      end
      HALTED: begin
        if (exception) begin
          pc_next    = EXC_VECTOR;
          epc_next   = pc_out;
          state_next = RUN;
        end else if (resume) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      pc_out   <= RESET_VECTOR;
      epc      <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_next;
      pc_out   <= pc_next;
      epc      <= epc_next;
      misalign <= misalign_next;
    end
  end

  // Push overwrites the oldest slot when full because the pointer simply wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (ras_push) begin
      ras_mem[ras_ptr] <= pc_plus4;
      ras_ptr          <= ras_ptr + PW'(1);
      if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + CW'(1);
    end else if (ras_pop) begin
      ras_ptr <= ras_ptr - PW'(1);
      ras_cnt <= ras_cnt - CW'(1);
    end
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- XLEN, 32, PC / address width (>=8).
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- EXC_VECTOR, 32'h0000_0080, PC value loaded on exception.
- RAS_DEPTH, 4, return-address-stack entries (power of 2, >=2).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock; all state on rising edge.
- reset, in, 1, asynchronous, active-high.
- stall, in, 1, hold PC and all state.
- branch_taken, in, 1, redirect to branch_target.
- branch_target, in, XLEN, branch destination.
- jump, in, 1, redirect to jump_target.
- jump_target, in, XLEN, jump destination.
- link, in, 1, qualifies jump as call: push pc_out+4 onto RAS.
- ret, in, 1, return: pop RAS.
- ret_target, in, XLEN, fallback return address (register value).
- exception, in, 1, trap request.
- eret, in, 1, return from exception.
- halt, in, 1, request halt.
- resume, in, 1, leave HALTED.
- pc_out, out, XLEN, current fetch PC (registered).
- pc_plus4, out, XLEN, pc_out+4 (combinational).
- epc, out, XLEN, saved exception PC (registered).
- misalign, out, 1, one-cycle pulse: misaligned redirect trapped.
- halted, out, 1, high in HALTED state.
- ras_empty, out, 1, RAS holds no entries.

Function
REQ-003 SHALL implement two states: RUN and HALTED.
REQ-004 In RUN, SHALL select next PC on each rising edge by fixed priority: exception > eret > branch_taken > jump > ret > stall > pc_out+4.
REQ-005 stall SHALL hold pc_out, epc, RAS and state only when no higher-priority event is asserted; exception, eret and redirects override stall.
REQ-006 pc_out+4 SHALL wrap modulo 2^XLEN (all-ones-minus-3 + 4 -> 0, no flag).
REQ-007 exception SHALL load pc_out <= EXC_VECTOR and epc <= pc_out.
REQ-008 eret SHALL load pc_out <= epc; epc unchanged.
REQ-009 A selected branch/jump/ret target with bits [1:0] != 0 SHALL NOT load the target; it SHALL load pc_out <= EXC_VECTOR, epc <= the target, and pulse misalign for exactly one cycle.
REQ-010 jump with link SHALL push pc_out+4 onto RAS in the same edge the jump is taken; link without jump SHALL be ignored.
REQ-011 RAS push when full SHALL overwrite the oldest entry (circular); occupancy saturates at RAS_DEPTH.
REQ-012 ret with RAS non-empty SHALL load pc_out <= top entry and pop; ret with RAS empty SHALL load pc_out <= ret_target, no pop.
REQ-013 RAS SHALL be modified only when its owning event (jump+link or ret) is the selected event; lost-priority events have no side effect.
REQ-014 halt in RUN with no higher-priority event SHALL load pc_out <= pc_out+4, enter HALTED and hold at that value.
REQ-015 In HALTED, pc_out SHALL hold; resume -> RUN next edge with no PC change; exception -> RUN with REQ-007 behaviour; all other inputs ignored.
REQ-016 halted SHALL equal (state == HALTED); ras_empty SHALL equal (occupancy == 0).

Reset
REQ-017 reset SHALL asynchronously force pc_out = RESET_VECTOR, epc = 0, state = RUN, RAS occupancy = 0, misalign = 0.
REQ-018 reset asserted mid-operation (any state, any event pending) SHALL override all inputs; the first edge after deassert SHALL produce RESET_VECTOR+4 unless an event is asserted.

Verification
REQ-019 Bench SHALL cover:
- reset pulse between clock edges -> pc_out = 0 immediately; 3 free edges -> 4, 8, 0xC.
- pc_out=0x40, jump=1, link=1, jump_target=0x200; next edge ret=1 -> pc_out 0x200, then 0x44; ras_empty returns to 1.
- 5 calls with RAS_DEPTH=4, then 5 rets -> 4 most recent return addresses in LIFO order; 5th ret uses ret_target.
- pc_out=0x100, stall=1 and exception=1 same edge -> pc_out=0x80, epc=0x100; then eret -> pc_out=0x100.
- branch_taken=1, branch_target=0x302 -> pc_out=0x80, epc=0x302, misalign high exactly one cycle.
- pc_out=0x10, halt=1 -> pc_out=0x14, halted=1 held 10 cycles; resume -> next edge 0x18 follows.
